// File: rtl/flash_tlul_pkg.sv
// Shared types and constants for the flash TL-UL responder: FSM state enum,
// TL-UL opcode encodings, flash window size and the largest legal read size.
package flash_tlul_pkg;

    import top_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    // The flash window is 2^WIN_BITS bytes; BaseAddr must be aligned to it.
    localparam int WIN_BITS = 18;

    // Reads wider than one 32-bit word are rejected.
    localparam logic [TL_SZW-1:0] MAX_RD_SIZE = TL_SZW'(2);

endpackage

// File: rtl/top_pkg.sv
// Bus and flash width constants shared by the TL-UL fabric and the flash
// controller. Other blocks size their ports from these values.
package top_pkg;

    localparam int TL_AW    = 32;        // TL-UL byte address width
    localparam int TL_DW    = 32;        // TL-UL data width
    localparam int TL_DBW   = TL_DW / 8; // byte-mask width
    localparam int TL_SZW   = 2;         // size field (log2 bytes)
    localparam int TL_AIW   = 8;         // A-channel source ID width
    localparam int TL_DIW   = 1;         // D-channel sink ID width
    localparam int TL_DUW   = 16;        // D-channel user width
    localparam int FLASH_AW = 16;        // flash word address (256 KiB of 32-bit words)
    localparam int FLASH_DW = 32;        // flash read word width

endpackage

// File: rtl/flash_tlul_req_chk.sv
// Combinational request classifier.
//   opcode_i   : A-channel opcode
//   addr_win_i : address bits above the flash window offset
//   size_i     : A-channel size (log2 bytes)
//   good_o     : request is a legal in-window read that must go to flash
//   d_opcode_o : D opcode for an error response (AccessAck for Puts,
//                AccessAckData for everything else)
module flash_tlul_req_chk
    import top_pkg::*;
    import flash_tlul_pkg::*;
#(
    parameter logic [TL_AW-1:0] BaseAddr = 32'h2000_0000
) (
    input  logic [2:0]                opcode_i,
    input  logic [TL_AW-WIN_BITS-1:0] addr_win_i,
    input  logic [TL_SZW-1:0]         size_i,
    output logic                      good_o,
    output logic [2:0]                d_opcode_o
);

    logic is_get;
    logic is_put;
    logic in_window;
    logic size_ok;

    assign is_get    = (opcode_i == OP_GET);
    assign is_put    = (opcode_i == OP_PUT_FULL) || (opcode_i == OP_PUT_PARTIAL);
    assign in_window = (addr_win_i == BaseAddr[TL_AW-1:WIN_BITS]);
    assign size_ok   = (size_i <= MAX_RD_SIZE);

    assign good_o     = is_get & in_window & size_ok;
    assign d_opcode_o = is_put ? OP_ACCESS_ACK : OP_ACCESS_ACK_DATA;

endmodule

// File: rtl/flash_tlul_rsp.sv
// TL-UL device responder for embedded-flash reads. Accepts one request at a
// time, performs a single read handshake with the flash controller for legal
// in-window Gets, and answers everything else with an error response.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   tl_a_*            : TL-UL A channel (request) from the crossbar
//   tl_d_*            : TL-UL D channel (response) to the crossbar
//   flash_req_o/addr_o: read request to the flash controller, held until done
//   flash_rd_*_i      : read completion pulse, data and error from flash
module flash_tlul_rsp
    import top_pkg::*;
    import flash_tlul_pkg::*;
#(
    parameter logic [TL_AW-1:0] BaseAddr = 32'h2000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tl_a_valid_i,
    output logic                 tl_a_ready_o,
    input  logic [2:0]           tl_a_opcode_i,
    input  logic [TL_SZW-1:0]    tl_a_size_i,
    input  logic [TL_AIW-1:0]    tl_a_source_i,
    input  logic [TL_AW-1:0]     tl_a_address_i,
    input  logic [TL_DBW-1:0]    tl_a_mask_i,
    output logic                 tl_d_valid_o,
    input  logic                 tl_d_ready_i,
    output logic [2:0]           tl_d_opcode_o,
    output logic [TL_SZW-1:0]    tl_d_size_o,
    output logic [TL_AIW-1:0]    tl_d_source_o,
    output logic [TL_DIW-1:0]    tl_d_sink_o,
    output logic [TL_DUW-1:0]    tl_d_user_o,
    output logic [TL_DW-1:0]     tl_d_data_o,
    output logic                 tl_d_error_o,
    output logic                 flash_req_o,
    output logic [FLASH_AW-1:0]  flash_addr_o,
    input  logic                 flash_rd_done_i,
    input  logic [FLASH_DW-1:0]  flash_rdata_i,
    input  logic                 flash_rd_err_i
);

    state_e               state_q, state_d;
    logic [TL_AIW-1:0]    source_q, source_d;
    logic [TL_SZW-1:0]    size_q, size_d;
    logic [FLASH_AW-1:0]  addr_q, addr_d;
    logic [2:0]           d_opcode_q, d_opcode_d;
    logic [TL_DW-1:0]     data_q, data_d;
    logic                 error_q, error_d;

    logic                 req_good;
    logic [2:0]           req_d_opcode;
    logic                 d_valid;

    // Mask is irrelevant for reads and writes are never executed; sub-word
    // reads return the whole aligned word, so the byte offset is dropped.
    logic unused_inputs;
    assign unused_inputs = ^{tl_a_mask_i, tl_a_address_i[1:0]};

    flash_tlul_req_chk #(
        .BaseAddr(BaseAddr)
    ) u_req_chk (
        .opcode_i  (tl_a_opcode_i),
        .addr_win_i(tl_a_address_i[TL_AW-1:WIN_BITS]),
        .size_i    (tl_a_size_i),
        .good_o    (req_good),
        .d_opcode_o(req_d_opcode)
    );

    always_comb begin
        state_d    = state_q;
        source_d   = source_q;
        size_d     = size_q;
        addr_d     = addr_q;
        d_opcode_d = d_opcode_q;
        data_d     = data_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (tl_a_valid_i) begin
                    source_d   = tl_a_source_i;
                    size_d     = tl_a_size_i;
                    addr_d     = tl_a_address_i[FLASH_AW+1:2];
                    data_d     = '0;
                    d_opcode_d = req_d_opcode;
                    if (req_good) begin
                        error_d = 1'b0;
                        state_d = ST_READ;
                    end else begin
                        // Rejected requests skip flash entirely.
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_READ: begin
                if (flash_rd_done_i) begin
                    data_d     = flash_rd_err_i ? '0 : flash_rdata_i;
                    error_d    = flash_rd_err_i;
                    d_opcode_d = OP_ACCESS_ACK_DATA;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tl_d_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            source_q   <= '0;
            size_q     <= '0;
            addr_q     <= '0;
            d_opcode_q <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            source_q   <= source_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            d_opcode_q <= d_opcode_d;
            data_q     <= data_d;
            error_q    <= error_d;
        end
    end

    // Handshake outputs depend only on state, never on inputs.
    assign tl_a_ready_o = (state_q == ST_IDLE);
    assign d_valid      = (state_q == ST_RESP);
    assign flash_req_o  = (state_q == ST_READ);
    assign flash_addr_o = addr_q;

    // D payload is driven only while a response is presented, so the bus
    // sees zeros between responses.
    assign tl_d_valid_o  = d_valid;
    assign tl_d_opcode_o = d_valid ? d_opcode_q : '0;
    assign tl_d_size_o   = d_valid ? size_q     : '0;
    assign tl_d_source_o = d_valid ? source_q   : '0;
    assign tl_d_data_o   = d_valid ? data_q     : '0;
    assign tl_d_error_o  = d_valid ? error_q    : 1'b0;
    assign tl_d_sink_o   = '0;
    assign tl_d_user_o   = '0;

endmodule

// File: tb/tb_flash_tlul_rsp.sv
// Self-checking bench for flash_tlul_rsp. The driver turns each transaction
// into a cycle-by-cycle expectation (exp_*) derived from the request/response
// timing rules; a single compare process checks the DUT on every negedge.
module tb_flash_tlul_rsp;
    import top_pkg::*;

    localparam logic [31:0] BASE     = 32'h2000_0000;
    localparam logic [31:0] WIN_SIZE = 32'h0004_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_i;
    logic                tl_a_valid_i;
    logic                tl_a_ready_o;
    logic [2:0]          tl_a_opcode_i;
    logic [TL_SZW-1:0]   tl_a_size_i;
    logic [TL_AIW-1:0]   tl_a_source_i;
    logic [TL_AW-1:0]    tl_a_address_i;
    logic [TL_DBW-1:0]   tl_a_mask_i;
    logic                tl_d_valid_o;
    logic                tl_d_ready_i;
    logic [2:0]          tl_d_opcode_o;
    logic [TL_SZW-1:0]   tl_d_size_o;
    logic [TL_AIW-1:0]   tl_d_source_o;
    logic [TL_DIW-1:0]   tl_d_sink_o;
    logic [TL_DUW-1:0]   tl_d_user_o;
    logic [TL_DW-1:0]    tl_d_data_o;
    logic                tl_d_error_o;
    logic                flash_req_o;
    logic [FLASH_AW-1:0] flash_addr_o;
    logic                flash_rd_done_i;
    logic [FLASH_DW-1:0] flash_rdata_i;
    logic                flash_rd_err_i;

    flash_tlul_rsp #(.BaseAddr(BASE)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .tl_a_valid_i   (tl_a_valid_i),
        .tl_a_ready_o   (tl_a_ready_o),
        .tl_a_opcode_i  (tl_a_opcode_i),
        .tl_a_size_i    (tl_a_size_i),
        .tl_a_source_i  (tl_a_source_i),
        .tl_a_address_i (tl_a_address_i),
        .tl_a_mask_i    (tl_a_mask_i),
        .tl_d_valid_o   (tl_d_valid_o),
        .tl_d_ready_i   (tl_d_ready_i),
        .tl_d_opcode_o  (tl_d_opcode_o),
        .tl_d_size_o    (tl_d_size_o),
        .tl_d_source_o  (tl_d_source_o),
        .tl_d_sink_o    (tl_d_sink_o),
        .tl_d_user_o    (tl_d_user_o),
        .tl_d_data_o    (tl_d_data_o),
        .tl_d_error_o   (tl_d_error_o),
        .flash_req_o    (flash_req_o),
        .flash_addr_o   (flash_addr_o),
        .flash_rd_done_i(flash_rd_done_i),
        .flash_rdata_i  (flash_rdata_i),
        .flash_rd_err_i (flash_rd_err_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle
    logic                chk_en      = 1'b0;
    logic                exp_zero    = 1'b0;
    logic                exp_a_ready = 1'b1;
    logic                exp_d_valid = 1'b0;
    logic                exp_req     = 1'b0;
    logic [2:0]          exp_op      = '0;
    logic [TL_SZW-1:0]   exp_size    = '0;
    logic [TL_AIW-1:0]   exp_src     = '0;
    logic [31:0]         exp_data    = '0;
    logic                exp_err     = 1'b0;
    logic [FLASH_AW-1:0] exp_faddr   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("a_ready",   32'(tl_a_ready_o), 32'(exp_a_ready));
                check("d_valid",   32'(tl_d_valid_o), 32'(exp_d_valid));
                check("flash_req", 32'(flash_req_o),  32'(exp_req));
                check("d_sink",    32'(tl_d_sink_o),  32'd0);
                check("d_user",    32'(tl_d_user_o),  32'd0);
                if (exp_req) begin
                    check("flash_addr", 32'(flash_addr_o), 32'(exp_faddr));
                end
                if (exp_d_valid) begin
                    check("d_opcode", 32'(tl_d_opcode_o), 32'(exp_op));
                    check("d_size",   32'(tl_d_size_o),   32'(exp_size));
                    check("d_source", 32'(tl_d_source_o), 32'(exp_src));
                    check("d_data",   32'(tl_d_data_o),   exp_data);
                    check("d_error",  32'(tl_d_error_o),  32'(exp_err));
                end
                if (exp_zero) begin
                    check("rst_d_opcode",   32'(tl_d_opcode_o), 32'd0);
                    check("rst_d_size",     32'(tl_d_size_o),   32'd0);
                    check("rst_d_source",   32'(tl_d_source_o), 32'd0);
                    check("rst_d_data",     32'(tl_d_data_o),   32'd0);
                    check("rst_d_error",    32'(tl_d_error_o),  32'd0);
                    check("rst_flash_addr", 32'(flash_addr_o),  32'd0);
                end
            end
        end
    end

    // Reference model: what the response must be, from the request alone
    function automatic void model(
        input  logic [2:0]          op,
        input  logic [31:0]         addr,
        input  logic [TL_SZW-1:0]   sz,
        input  logic                ferr,
        input  logic [31:0]         rdata,
        output logic                good,
        output logic [2:0]          dop,
        output logic [31:0]         ddata,
        output logic                derr,
        output logic [FLASH_AW-1:0] faddr
    );
        good  = (op == 3'd4) && (addr >= BASE) && ((addr - BASE) < WIN_SIZE) && (sz <= 2'd2);
        dop   = good ? 3'd1 : ((op == 3'd0 || op == 3'd1) ? 3'd0 : 3'd1);
        derr  = good ? ferr : 1'b1;
        ddata = (good && !ferr) ? rdata : 32'd0;
        faddr = FLASH_AW'((addr - BASE) / 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_a_ready = 1'b1;
        exp_d_valid = 1'b0;
        exp_req     = 1'b0;
    endtask

    // Idle cycles, with occasional stray done pulses that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tl_a_valid_i    = 1'b0;
            flash_rd_done_i = ($urandom_range(0, 3) == 0);
            flash_rdata_i   = $urandom;
            flash_rd_err_i  = 1'($urandom);
            set_idle_exp();
            step();
        end
        flash_rd_done_i = 1'b0;
    endtask

    // One request/response transaction, starting in a cycle where the DUT is idle
    task automatic txn(
        input logic [2:0]          op,
        input logic [31:0]         addr,
        input logic [TL_SZW-1:0]   sz,
        input logic [TL_AIW-1:0]   src,
        input int                  ndone,
        input logic                ferr,
        input logic [31:0]         rdata,
        input int                  nrdy,
        input logic                good,
        input logic [2:0]          dop,
        input logic [31:0]         ddata,
        input logic                derr,
        input logic [FLASH_AW-1:0] faddr
    );
        $display("txn op=%0d addr=%h size=%0d src=%h done_dly=%0d ferr=%0b rdy_dly=%0d -> good=%0b dop=%0d err=%0b data=%h",
                 op, addr, sz, src, ndone, ferr, nrdy, good, dop, derr, ddata);
        // cycle 0: accept
        tl_a_valid_i    = 1'b1;
        tl_a_opcode_i   = op;
        tl_a_address_i  = addr;
        tl_a_size_i     = sz;
        tl_a_source_i   = src;
        tl_a_mask_i     = TL_DBW'($urandom);
        tl_d_ready_i    = 1'b0;
        flash_rd_done_i = 1'b0;
        set_idle_exp();
        step();
        tl_a_valid_i   = 1'b0;
        tl_a_opcode_i  = 3'($urandom);
        tl_a_address_i = $urandom;
        if (good) begin
            for (int c = 1; c <= ndone; c++) begin
                exp_a_ready     = 1'b0;
                exp_d_valid     = 1'b0;
                exp_req         = 1'b1;
                exp_faddr       = faddr;
                flash_rd_done_i = (c == ndone);
                flash_rd_err_i  = (c == ndone) ? ferr : 1'($urandom);
                flash_rdata_i   = (c == ndone) ? rdata : $urandom;
                step();
            end
            flash_rd_done_i = 1'b0;
        end
        for (int r = 0; r <= nrdy; r++) begin
            exp_a_ready  = 1'b0;
            exp_d_valid  = 1'b1;
            exp_req      = 1'b0;
            exp_op       = dop;
            exp_size     = sz;
            exp_src      = src;
            exp_data     = ddata;
            exp_err      = derr;
            tl_d_ready_i = (r == nrdy);
            step();
        end
        tl_d_ready_i = 1'b0;
        set_idle_exp();
    endtask

    task automatic rand_txn();
        int          op_tbl[10] = '{0, 1, 4, 4, 4, 2, 3, 5, 6, 7};
        logic [2:0]          op;
        logic [31:0]         addr;
        logic [TL_SZW-1:0]   sz;
        logic [TL_AIW-1:0]   src;
        logic                ferr;
        logic [31:0]         rdata;
        logic                good;
        logic [2:0]          dop;
        logic [31:0]         ddata;
        logic                derr;
        logic [FLASH_AW-1:0] faddr;
        op    = 3'(op_tbl[$urandom_range(0, 9)]);
        addr  = ($urandom_range(0, 2) != 0) ? BASE + 32'($urandom_range(0, 32'h3FFFF)) : $urandom;
        sz    = TL_SZW'($urandom_range(0, 3));
        src   = TL_AIW'($urandom);
        ferr  = ($urandom_range(0, 3) == 0);
        rdata = $urandom;
        model(op, addr, sz, ferr, rdata, good, dop, ddata, derr, faddr);
        txn(op, addr, sz, src, int'($urandom_range(1, 4)), ferr, rdata,
            int'($urandom_range(0, 3)), good, dop, ddata, derr, faddr);
        idle(int'($urandom_range(0, 2)));
    endtask

    initial begin
        rst_i           = 1'b1;
        tl_a_valid_i    = 1'b0;
        tl_a_opcode_i   = '0;
        tl_a_size_i     = '0;
        tl_a_source_i   = '0;
        tl_a_address_i  = '0;
        tl_a_mask_i     = '0;
        tl_d_ready_i    = 1'b0;
        flash_rd_done_i = 1'b0;
        flash_rdata_i   = '0;
        flash_rd_err_i  = 1'b0;

        // Reset state
        step();
        chk_en   = 1'b1;
        exp_zero = 1'b1;
        set_idle_exp();
        step();
        rst_i = 1'b0;
        step();
        exp_zero = 1'b0;

        // Hand-computed expectations
        // good read, done one cycle after request
        txn(3'd4, 32'h2000_0104, 2'd2, 8'h5A, 1, 1'b0, 32'hDEAD_BEEF, 0,
            1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0, 16'h0041);
        // PutFull rejected with AccessAck
        txn(3'd0, 32'h2000_0000, 2'd2, 8'h11, 1, 1'b0, 32'h0, 0,
            1'b0, 3'd0, 32'h0, 1'b1, 16'h0000);
        // just outside the window
        txn(3'd4, 32'h2004_0000, 2'd2, 8'h22, 1, 1'b0, 32'h0, 0,
            1'b0, 3'd1, 32'h0, 1'b1, 16'h0000);
        // size 3 is too wide
        txn(3'd4, 32'h2000_0000, 2'd3, 8'h33, 1, 1'b0, 32'h0, 0,
            1'b0, 3'd1, 32'h0, 1'b1, 16'h0000);
        // backpressure: ready low for 5 cycles
        txn(3'd4, 32'h2000_0010, 2'd2, 8'h03, 2, 1'b0, 32'hCAFE_F00D, 5,
            1'b1, 3'd1, 32'hCAFE_F00D, 1'b0, 16'h0004);
        // flash error zeroes the data
        txn(3'd4, 32'h2000_0020, 2'd2, 8'h44, 1, 1'b1, 32'h0000_1234, 0,
            1'b1, 3'd1, 32'h0, 1'b1, 16'h0008);
        // PutPartial at the top word of the window
        txn(3'd1, 32'h2003_FFFC, 2'd2, 8'h55, 1, 1'b0, 32'h0, 1,
            1'b0, 3'd0, 32'h0, 1'b1, 16'h0000);
        // byte read of the last byte of the window returns its aligned word
        txn(3'd4, 32'h2003_FFFF, 2'd0, 8'h66, 3, 1'b0, 32'h0BAD_F00D, 0,
            1'b1, 3'd1, 32'h0BAD_F00D, 1'b0, 16'hFFFF);
        // illegal opcode 2 is answered with AccessAckData + error
        txn(3'd2, 32'h2000_0040, 2'd2, 8'h77, 1, 1'b0, 32'h0, 0,
            1'b0, 3'd1, 32'h0, 1'b1, 16'h0000);
        idle(1);

        // Reset while the flash read is outstanding
        $display("txn reset during read addr=20000200");
        tl_a_valid_i   = 1'b1;
        tl_a_opcode_i  = 3'd4;
        tl_a_address_i = 32'h2000_0200;
        tl_a_size_i    = 2'd2;
        tl_a_source_i  = 8'h99;
        set_idle_exp();
        step();
        tl_a_valid_i = 1'b0;
        exp_a_ready  = 1'b0;
        exp_req      = 1'b1;
        exp_faddr    = 16'h0080;
        step();
        rst_i = 1'b1;
        step();
        rst_i    = 1'b0;
        exp_zero = 1'b1;
        set_idle_exp();
        step();
        exp_zero        = 1'b0;
        flash_rd_done_i = 1'b1;
        flash_rdata_i   = 32'h5555_AAAA;
        flash_rd_err_i  = 1'b0;
        step();
        flash_rd_done_i = 1'b0;
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_txn();
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
